// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters and
// saturating hit/mispredict statistics; lookup is combinational, update is clocked.
module branch_target_buffer #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 26,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [31:0]           Fetch_PC,
    input  logic                  Fetch_Valid,
    output logic                  BTB_Hit,
    output logic [1:0]            branchPredict,
    output logic                  Predict_Taken,
    output logic [31:0]           Predicted_PC,
    input  logic                  Update_Valid,
    input  logic [31:0]           Update_PC,
    input  logic                  Update_Taken,
    input  logic [31:0]           Update_Target,
    input  logic                  Update_Mispredict,
    output logic [STAT_WIDTH-1:0] Hit_Count,
    output logic [STAT_WIDTH-1:0] Mispredict_Count
);

    localparam int ENTRIES = 2 ** INDEX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] fetch_idx;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0]   upd_tag;
    logic                  upd_hit;
    logic                  unused_bits;

    assign fetch_idx   = Fetch_PC[INDEX_BITS+1:2];
    assign fetch_tag   = Fetch_PC[31:INDEX_BITS+2];
    assign upd_idx     = Update_PC[INDEX_BITS+1:2];
    assign upd_tag     = Update_PC[31:INDEX_BITS+2];
    assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign unused_bits = ^{Fetch_PC[1:0], Update_PC[1:0]};

    // Lookup reads only registered array state, so an update in the same cycle
    // becomes visible on the following cycle.
    always_comb begin
        BTB_Hit       = 1'b0;
        branchPredict = 2'b01;
        Predict_Taken = 1'b0;
        Predicted_PC  = Fetch_PC + 32'd4;
        if (valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag)) begin
            BTB_Hit       = 1'b1;
            branchPredict = ctr_q[fetch_idx];
            Predict_Taken = ctr_q[fetch_idx][1];
            if (ctr_q[fetch_idx][1]) begin
                Predicted_PC = target_q[fetch_idx];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            // NOTE: the whole array is cleared here because a reset must flush
            // every prediction; this forces flops rather than an SRAM macro.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            Hit_Count        <= '0;
            Mispredict_Count <= '0;
        end else begin
            if (Update_Valid) begin
                if (upd_hit) begin
                    if (Update_Taken) begin
                        target_q[upd_idx] <= Update_Target;
                        if (ctr_q[upd_idx] != 2'b11) begin
                            ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
                        end
                    end else if (ctr_q[upd_idx] != 2'b00) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
                    end
                end else if (Update_Taken) begin
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    target_q[upd_idx] <= Update_Target;
                    ctr_q[upd_idx]    <= 2'b10;
                end
            end
            if (Fetch_Valid && BTB_Hit && (Hit_Count != '1)) begin
                Hit_Count <= Hit_Count + STAT_WIDTH'(1);
            end
            if (Update_Valid && Update_Mispredict && (Mispredict_Count != '1)) begin
                Mispredict_Count <= Mispredict_Count + STAT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer: lookup, counter
// saturation, replacement, read-during-write, statistics saturation and reset.
module tb_branch_target_buffer;

    localparam int STAT_WIDTH = 16;

    logic                  Clk = 1'b0;
    logic                  Reset_n;
    logic [31:0]           Fetch_PC;
    logic                  Fetch_Valid;
    logic                  BTB_Hit;
    logic [1:0]            branchPredict;
    logic                  Predict_Taken;
    logic [31:0]           Predicted_PC;
    logic                  Update_Valid;
    logic [31:0]           Update_PC;
    logic                  Update_Taken;
    logic [31:0]           Update_Target;
    logic                  Update_Mispredict;
    logic [STAT_WIDTH-1:0] Hit_Count;
    logic [STAT_WIDTH-1:0] Mispredict_Count;

    int n_checks = 0;
    int n_fail   = 0;

    branch_target_buffer #(
        .INDEX_BITS(4),
        .TAG_BITS  (26),
        .STAT_WIDTH(STAT_WIDTH)
    ) dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .Fetch_PC         (Fetch_PC),
        .Fetch_Valid      (Fetch_Valid),
        .BTB_Hit          (BTB_Hit),
        .branchPredict    (branchPredict),
        .Predict_Taken    (Predict_Taken),
        .Predicted_PC     (Predicted_PC),
        .Update_Valid     (Update_Valid),
        .Update_PC        (Update_PC),
        .Update_Taken     (Update_Taken),
        .Update_Target    (Update_Target),
        .Update_Mispredict(Update_Mispredict),
        .Hit_Count        (Hit_Count),
        .Mispredict_Count (Mispredict_Count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        Update_Valid  = 1'b1;
        Update_PC     = pc;
        Update_Taken  = taken;
        Update_Target = tgt;
    endtask

    task automatic fetch(input logic [31:0] pc);
        Fetch_PC = pc;
        #1;
    endtask

    initial begin
        Reset_n           = 1'b0;
        Fetch_PC          = 32'h0040_0010;
        Fetch_Valid       = 1'b1;
        Update_Valid      = 1'b0;
        Update_PC         = '0;
        Update_Taken      = 1'b0;
        Update_Target     = '0;
        Update_Mispredict = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        #1;
        check("rst_hit",    32'(BTB_Hit),          32'd0);
        check("rst_bp",     32'(branchPredict),    32'd1);
        check("rst_taken",  32'(Predict_Taken),    32'd0);
        check("rst_pc",     Predicted_PC,          32'h0040_0014);
        check("rst_hitcnt", 32'(Hit_Count),        32'd0);
        check("rst_miscnt", 32'(Mispredict_Count), 32'd0);
        tick();
        check("miss_hitcnt", 32'(Hit_Count), 32'd0);
        Fetch_Valid = 1'b0;

        // Allocate on taken; same-cycle lookup still sees the miss.
        upd(32'h0040_0010, 1'b1, 32'h0040_0040);
        #1;
        check("rdw_miss", 32'(BTB_Hit), 32'd0);
        tick();
        Update_Valid = 1'b0;
        #1;
        check("alloc_hit",   32'(BTB_Hit),       32'd1);
        check("alloc_bp",    32'(branchPredict), 32'd2);
        check("alloc_taken", 32'(Predict_Taken), 32'd1);
        check("alloc_pc",    Predicted_PC,       32'h0040_0040);

        upd(32'h0040_0010, 1'b1, 32'h0040_0040);
        repeat (4) tick();
        Update_Valid = 1'b0;
        #1;
        check("sat_hi_bp", 32'(branchPredict), 32'd3);

        upd(32'h0040_0010, 1'b0, 32'h0000_0000);
        tick();
        check("nt1_bp", 32'(branchPredict), 32'd2);
        check("nt1_pc", Predicted_PC,       32'h0040_0040);
        tick();
        check("nt2_bp",    32'(branchPredict), 32'd1);
        check("nt2_taken", 32'(Predict_Taken), 32'd0);
        check("nt2_pc",    Predicted_PC,       32'h0040_0014);
        tick();
        tick();
        Update_Valid = 1'b0;
        #1;
        check("sat_lo_bp",  32'(branchPredict), 32'd0);
        check("sat_lo_hit", 32'(BTB_Hit),       32'd1);
        check("sat_lo_pc",  Predicted_PC,       32'h0040_0014);

        // Same index, different tag replaces the occupant.
        upd(32'h0040_0010, 1'b1, 32'h0040_0040);
        tick();
        upd(32'h0040_0050, 1'b1, 32'h0040_0100);
        tick();
        Update_Valid = 1'b0;
        fetch(32'h0040_0010);
        check("repl_old_hit", 32'(BTB_Hit), 32'd0);
        check("repl_old_pc",  Predicted_PC, 32'h0040_0014);
        fetch(32'h0040_0050);
        check("repl_new_hit", 32'(BTB_Hit),       32'd1);
        check("repl_new_bp",  32'(branchPredict), 32'd2);
        check("repl_new_pc",  Predicted_PC,       32'h0040_0100);

        // Same-cycle fetch and update on an empty entry.
        fetch(32'h0040_0020);
        upd(32'h0040_0020, 1'b1, 32'h0040_0080);
        #1;
        check("sc_miss", 32'(BTB_Hit), 32'd0);
        check("sc_bp",   32'(branchPredict), 32'd1);
        tick();
        Update_Valid = 1'b0;
        #1;
        check("sc_hit", 32'(BTB_Hit),  32'd1);
        check("sc_pc",  Predicted_PC,  32'h0040_0080);

        // Not-taken to an empty entry allocates nothing; mispredict counted.
        upd(32'h0040_0030, 1'b0, 32'h0040_0300);
        Update_Mispredict = 1'b1;
        tick();
        Update_Valid      = 1'b0;
        Update_Mispredict = 1'b0;
        fetch(32'h0040_0030);
        check("nt_empty_hit", 32'(BTB_Hit),          32'd0);
        check("nt_empty_bp",  32'(branchPredict),    32'd1);
        check("miscnt_one",   32'(Mispredict_Count), 32'd1);

        fetch(32'hFFFF_FFFC);
        check("wrap_pc", Predicted_PC, 32'h0000_0000);

        fetch(32'h0040_0050);
        Fetch_Valid = 1'b1;
        tick();
        Fetch_Valid = 1'b0;
        #1;
        check("hitcnt_one", 32'(Hit_Count), 32'd1);

        // Statistics saturation.
        Fetch_Valid       = 1'b1;
        upd(32'h0040_0030, 1'b0, 32'h0000_0000);
        Update_Mispredict = 1'b1;
        repeat ((1 << STAT_WIDTH) + 5) tick();
        check("sat_hitcnt", 32'(Hit_Count),        32'h0000_FFFF);
        check("sat_miscnt", 32'(Mispredict_Count), 32'h0000_FFFF);
        check("sat_hit",    32'(BTB_Hit),          32'd1);

        // Reset mid-operation, with a coincident update that must be discarded.
        Reset_n = 1'b0;
        upd(32'h0040_0030, 1'b1, 32'h0040_0300);
        tick();
        Reset_n           = 1'b1;
        Update_Valid      = 1'b0;
        Update_Mispredict = 1'b0;
        Fetch_Valid       = 1'b0;
        #1;
        check("mrst_hitcnt", 32'(Hit_Count),        32'd0);
        check("mrst_miscnt", 32'(Mispredict_Count), 32'd0);
        check("mrst_hit_50", 32'(BTB_Hit),          32'd0);
        check("mrst_bp_50",  32'(branchPredict),    32'd1);
        fetch(32'h0040_0030);
        check("mrst_hit_30", 32'(BTB_Hit), 32'd0);
        fetch(32'h0040_0020);
        check("mrst_hit_20", 32'(BTB_Hit),  32'd0);
        check("mrst_pc_20",  Predicted_PC,  32'h0040_0024);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
